shuffled_cnu_serial: RTL and testbench
======================================

Name: shuffled_cnu_serial

Overview:
Serial min-sum check node unit for the shuffled LDPC decoder, at the opposite end of the variable-node update path.
- Input: one variable-to-check message per cycle for one parity row, 10-bit sign-magnitude, as produced by the VNU.
- Tracks min1, min2, min1 index and sign parity.
- Output: one check-to-variable message per cycle, 6-bit sign-magnitude, in the width the VNU consumes.
- Valid/ready handshake on both sides.

Parameters:
- DC, 4, check-node degree (messages per row), >= 2.
- IN_W, 10, input message width, sign-magnitude, MSB = sign.
- OUT_W, 6, output message width, sign-magnitude, MSB = sign.
- IDX_W, $clog2(DC), width of message index (localparam-derived).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  input message valid.
- o_ready  out  1  block accepts input (COLLECT state).
- i_data  in  IN_W  variable-to-check message, sign-magnitude.
- o_valid  out  1  output message valid.
- i_ready  in  1  downstream accepts output.
- o_data  out  OUT_W  check-to-variable message, sign-magnitude.
- o_idx  out  IDX_W  position of o_data within the row, 0..DC-1.
- o_last  out  1  high with the o_idx = DC-1 output.

Behaviour:
Reset values:
- State COLLECT; o_ready = 1; o_valid = 0; o_data = 0; o_idx = 0; o_last = 0.
- Internal min1/min2 = all-ones magnitude, idx1 = 0, sign parity = 0, sign store = 0, counter = 0.

FSM, two states:
- COLLECT: o_ready = 1, o_valid = 0.
  - Input handshake = i_valid & o_ready.
  - Each handshake stores sign bit s[cnt], XORs it into parity, and updates mins.
  - The DC-th handshake (cnt = DC-1) moves to EMIT next cycle.
- EMIT: o_ready = 0, o_valid = 1.
  - Output handshake = o_valid & i_ready advances out_cnt.
  - Handshake with out_cnt = DC-1 returns to COLLECT next cycle, clearing mins, parity and counters.
- No overlap between rows: input is not accepted in the cycle of the final output handshake.

Magnitude saturation: input magnitude (IN_W-1 bits) saturates to OUT_W-1 bits (max 31 at defaults) before comparison.

Min update, in the order: mag < min1 takes precedence over mag < min2.
- If mag < min1 (strict): min2 = min1, min1 = mag, idx1 = cnt.
- Else if mag < min2 (strict): min2 = mag.
- On a tie, the earliest index keeps min1 and the tying value becomes min2.

Output for position k:
- mag = (k == idx1) ? min2 : min1.
- sign = parity ^ s[k].
- If mag = 0, the sign is forced to 0 (no negative zero).

Timing:
- Latency: o_valid rises the cycle after the DC-th input handshake.
- Under continuous i_ready, one output per cycle.
- o_data, o_idx and o_last are registered and held stable while o_valid & !i_ready.

Other rules:
- Input sign bit is used as given; -0 counts as negative in parity.
- i_valid during EMIT is ignored.
- Reset mid-row: all state is discarded immediately (async) and the partial row is lost.

Optional Feature:
Macro SHUFFLED_CNU_OFFSET_EN.
- Defined: offset min-sum. Output magnitude = max(mag - 1, 0), applied after min2/min1 selection and before the zero-sign rule.
- Undefined: plain min-sum, magnitude passed unchanged.
- Latency is identical in both builds.

Decomposition:
- Package shuffled_ldpc_pkg holds:
  - localparams VN_MSG_W = 10 and CN_MSG_W = 6.
  - typedef enum logic {COLLECT, EMIT} cnu_state_t.
  - Function sm_sat(mag) for magnitude saturation.
- One sub-module: cnu_min_tracker, containing the min1/min2/idx1 registers and the update comparators, with clear and update strobes.
- FSM, sign store and output mux live in the top module.

Test Plan:
1. Basic row, DC = 4. Inputs (10-bit SM) +5, -3, +7, -9 -> o_data sequence 0x03, 0x25, 0x03, 0x23 (+3, -5, +3, -3); o_last on the 4th output; o_valid first high the cycle after the 4th input handshake.
2. Saturation. Inputs +200, +100, +60, +40 -> all outputs 0x1F (+31).
3. Tie and zero.
   - Inputs +4, +4, +9, +9 -> all outputs +4.
   - Inputs -0, +2, +3, +4 -> outputs +2 (0x02), then 0x00, 0x00, 0x00; no 0x20 ever emitted.
4. Backpressure. i_ready low for 3 cycles at o_idx = 2 -> o_data, o_idx and o_valid held constant; i_valid pulses during EMIT are ignored, and o_ready stays 0 until one cycle after the final handshake.
5. Reset mid-operation.
   - rst_n low during EMIT after o_idx = 1 -> next cycle all outputs at reset values.
   - A following clean row of +5, -3, +7, -9 produces the test 1 result.
6. Built with SHUFFLED_CNU_OFFSET_EN. Test 1 stimulus -> +2, -4, +2, -2 (0x02, 0x24, 0x02, 0x22); the -0, +2, +3, +4 row -> +1, then 0x00 three times.

Source files
------------

// File: rtl/shuffled_ldpc_pkg.sv
// Shared types, message widths and helpers for the shuffled LDPC decoder datapath.
`default_nettype none

package shuffled_ldpc_pkg;

  localparam int VN_MSG_W = 10;
  localparam int CN_MSG_W = 6;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } cnu_state_t;

  // Clamp an unsigned magnitude to the largest value representable in out_mag_w bits.
  function automatic logic [31:0] sm_sat(input logic [31:0] mag, input int unsigned out_mag_w);
    logic [31:0] max_mag;
    max_mag = (32'd1 << out_mag_w) - 32'd1;
    return (mag > max_mag) ? max_mag : mag;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shuffled_cnu_serial_min_tracker.sv
// cnu_min_tracker: running min1/min2/idx1 over one parity row, with clear and update strobes.
`default_nettype none

module cnu_min_tracker
  import shuffled_ldpc_pkg::*;
#(
  parameter int MAG_W = 5,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             update,
  input  logic [MAG_W-1:0] mag,
  input  logic [IDX_W-1:0] idx,
  output logic [MAG_W-1:0] min1,
  output logic [MAG_W-1:0] min2,
  output logic [IDX_W-1:0] idx1,
  output logic [MAG_W-1:0] min1_nxt,
  output logic [MAG_W-1:0] min2_nxt,
  output logic [IDX_W-1:0] idx1_nxt
);

  // Strict compares: on a tie the earlier index keeps min1 and the newcomer lands in min2.
  always_comb begin
    min1_nxt = min1;
    min2_nxt = min2;
    idx1_nxt = idx1;
    if (mag < min1) begin
      min2_nxt = min1;
      min1_nxt = mag;
      idx1_nxt = idx;
    end else if (mag < min2) begin
      min2_nxt = mag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min1 <= '1;
      min2 <= '1;
      idx1 <= '0;
    end else if (clear) begin
      min1 <= '1;
      min2 <= '1;
      idx1 <= '0;
    end else if (update) begin
      min1 <= min1_nxt;
      min2 <= min2_nxt;
      idx1 <= idx1_nxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/shuffled_cnu_serial.sv
// Serial min-sum check node unit: collects DC V2C messages, then emits DC C2V messages.
// SHUFFLED_CNU_OFFSET_EN selects offset min-sum (output magnitude reduced by one, floored at 0).
`default_nettype none

module shuffled_cnu_serial
  import shuffled_ldpc_pkg::*;
#(
  parameter int DC    = 4,
  parameter int IN_W  = VN_MSG_W,
  parameter int OUT_W = CN_MSG_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [IN_W-1:0]        i_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [OUT_W-1:0]       o_data,
  output logic [$clog2(DC)-1:0]  o_idx,
  output logic                   o_last
);

  localparam int               IDX_W    = $clog2(DC);
  localparam int               MAG_W    = OUT_W - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DC - 1);

  cnu_state_t       state, state_nxt;
  logic [IDX_W-1:0] in_cnt, out_cnt, out_cnt_inc;
  logic [DC-1:0]    signs, signs_nxt;
  logic             parity, parity_nxt;
  logic [MAG_W-1:0] in_mag, min1, min2, min1_nxt, min2_nxt;
  logic [IDX_W-1:0] idx1, idx1_nxt;
  logic             in_hs, in_done, out_hs, out_done;
  logic [OUT_W-1:0] data_q;
  logic             last_q;

  function automatic logic [OUT_W-1:0] out_msg(
    input logic [IDX_W-1:0] k,
    input logic [MAG_W-1:0] m1,
    input logic [MAG_W-1:0] m2,
    input logic [IDX_W-1:0] i1,
    input logic             par,
    input logic [DC-1:0]    sg
  );
    logic [MAG_W-1:0] mag;
    logic             sgn;
    mag = (k == i1) ? m2 : m1;
`ifdef SHUFFLED_CNU_OFFSET_EN
    mag = (mag == '0) ? '0 : mag - 1'b1;
`endif
    sgn = (mag == '0) ? 1'b0 : (par ^ sg[k]);
    return {sgn, mag};
  endfunction

  assign in_mag      = MAG_W'(sm_sat(32'(i_data[IN_W-2:0]), MAG_W));
  assign in_hs       = i_valid & o_ready;
  assign in_done     = in_hs & (in_cnt == LAST_IDX);
  assign out_hs      = o_valid & i_ready;
  assign out_done    = out_hs & (out_cnt == LAST_IDX);
  assign out_cnt_inc = out_cnt + 1'b1;
  assign parity_nxt  = parity ^ i_data[IN_W-1];

  always_comb begin
    signs_nxt         = signs;
    signs_nxt[in_cnt] = i_data[IN_W-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    case (state)
      COLLECT: begin
        o_ready = 1'b1;
        if (in_done) state_nxt = EMIT;
      end
      EMIT: begin
        o_valid = 1'b1;
        if (out_done) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  cnu_min_tracker #(
    .MAG_W (MAG_W),
    .IDX_W (IDX_W)
  ) u_min_tracker (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (out_done),
    .update   (in_hs),
    .mag      (in_mag),
    .idx      (in_cnt),
    .min1     (min1),
    .min2     (min2),
    .idx1     (idx1),
    .min1_nxt (min1_nxt),
    .min2_nxt (min2_nxt),
    .idx1_nxt (idx1_nxt)
  );

  // The first output is built from the tracker's next values so it is ready the cycle after the last input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt  <= '0;
      out_cnt <= '0;
      signs   <= '0;
      parity  <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (in_hs) begin
      signs  <= signs_nxt;
      parity <= parity_nxt;
      if (in_done) begin
        in_cnt  <= '0;
        out_cnt <= '0;
        data_q  <= out_msg('0, min1_nxt, min2_nxt, idx1_nxt, parity_nxt, signs_nxt);
        last_q  <= 1'b0;
      end else begin
        in_cnt <= in_cnt + 1'b1;
      end
    end else if (out_hs) begin
      if (out_done) begin
        in_cnt  <= '0;
        out_cnt <= '0;
        signs   <= '0;
        parity  <= 1'b0;
        data_q  <= '0;
        last_q  <= 1'b0;
      end else begin
        out_cnt <= out_cnt_inc;
        data_q  <= out_msg(out_cnt_inc, min1, min2, idx1, parity, signs);
        last_q  <= (out_cnt_inc == LAST_IDX);
      end
    end
  end

  assign o_data = data_q;
  assign o_idx  = out_cnt;
  assign o_last = last_q;

endmodule

`default_nettype wire

// File: tb/tb_shuffled_cnu_serial.sv
// Scoreboard bench for shuffled_cnu_serial (DC=4) with directed rows and hand-computed results.
`default_nettype none

module tb_shuffled_cnu_serial;

  typedef logic [9:0] vin_t [4];
  typedef logic [5:0] vout_t [4];

  logic       clk = 1'b0;
  logic       rst_n, i_valid, i_ready, o_ready, o_valid, o_last;
  logic [9:0] i_data;
  logic [5:0] o_data;
  logic [1:0] o_idx;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [8:0] exp_q [$];

  vin_t  v_basic, v_sat, v_tie, v_zero;
  vout_t e_basic, e_sat, e_tie, e_zero;
  logic [8:0] held;

  always #5 clk = ~clk;

  shuffled_cnu_serial #(.DC(4), .IN_W(10), .OUT_W(6)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_idx   (o_idx),
    .o_last  (o_last)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every output handshake pops one expected {last, idx, data}.
  always @(negedge clk) begin
    if (rst_n && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_output", {23'b0, o_last, o_idx, o_data}, 32'hFFFF_FFFF);
      end else begin
        chk("out_msg", {23'b0, o_last, o_idx, o_data}, {23'b0, exp_q.pop_front()});
      end
    end
  end

  task automatic push_exp(input vout_t e, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({(k == 3), 2'(k), e[k]});
  endtask

  task automatic send_row(input vin_t v);
    for (int k = 0; k < 4; k++) begin
      int guard;
      guard   = 0;
      i_valid = 1'b1;
      i_data  = v[k];
      @(negedge clk);
      while (!o_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) chk("input_accept_timeout", 32'd1, 32'd0);
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    chk("latency_valid", {31'b0, o_valid}, 32'd1);
    chk("latency_idx0", {30'b0, o_idx}, 32'd0);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((o_valid || exp_q.size() != 0) && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 100) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_idx2();
    int guard;
    guard = 0;
    while (!(o_valid && o_idx == 2'd2) && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 20) chk("idx2_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_o_ready"}, {31'b0, o_ready}, 32'd1);
    chk({tag, "_o_valid"}, {31'b0, o_valid}, 32'd0);
    chk({tag, "_o_data"},  {26'b0, o_data},  32'd0);
    chk({tag, "_o_idx"},   {30'b0, o_idx},   32'd0);
    chk({tag, "_o_last"},  {31'b0, o_last},  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "simulation did not finish");
  end

  initial begin
    v_basic = '{10'h005, 10'h203, 10'h007, 10'h209};
    v_sat   = '{10'h0C8, 10'h064, 10'h03C, 10'h028};
    v_tie   = '{10'h004, 10'h004, 10'h009, 10'h009};
    v_zero  = '{10'h200, 10'h002, 10'h003, 10'h004};
`ifdef SHUFFLED_CNU_OFFSET_EN
    e_basic = '{6'h02, 6'h24, 6'h02, 6'h22};
    e_sat   = '{6'h1E, 6'h1E, 6'h1E, 6'h1E};
    e_tie   = '{6'h03, 6'h03, 6'h03, 6'h03};
    e_zero  = '{6'h01, 6'h00, 6'h00, 6'h00};
`else
    e_basic = '{6'h03, 6'h25, 6'h03, 6'h23};
    e_sat   = '{6'h1F, 6'h1F, 6'h1F, 6'h1F};
    e_tie   = '{6'h04, 6'h04, 6'h04, 6'h04};
    e_zero  = '{6'h02, 6'h00, 6'h00, 6'h00};
`endif

    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic, saturation, tie and zero rows under continuous i_ready.
    push_exp(e_basic, 4); send_row(v_basic); wait_idle();
    push_exp(e_sat, 4);   send_row(v_sat);   wait_idle();
    push_exp(e_tie, 4);   send_row(v_tie);   wait_idle();
    push_exp(e_zero, 4);  send_row(v_zero);  wait_idle();

    // Backpressure at o_idx = 2 with i_valid held high throughout EMIT.
    push_exp(e_basic, 4);
    send_row(v_basic);
    wait_idx2();
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = 10'h001;
    held    = {o_valid, o_idx, o_data};
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("bp_hold", {23'b0, o_valid, o_idx, o_data}, {23'b0, held});
      chk("bp_o_ready", {31'b0, o_ready}, 32'd0);
    end
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_idx3", {30'b0, o_idx}, 32'd3);
    chk("bp_ready_before_last", {31'b0, o_ready}, 32'd0);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    chk("bp_ready_after_last", {31'b0, o_ready}, 32'd1);
    chk("bp_valid_after_last", {31'b0, o_valid}, 32'd0);
    push_exp(e_tie, 4); send_row(v_tie); wait_idle();

    // Reset in the middle of EMIT, then a clean row.
    push_exp(e_basic, 2);
    send_row(v_basic);
    wait_idx2();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    chk("midreset_queue", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_exp(e_basic, 4); send_row(v_basic); wait_idle();
    push_exp(e_zero, 4);  send_row(v_zero);  wait_idle();

    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
